// File: rtl/red_pitaya_limit_relock_ctrl_if.sv
// Configuration, status and rail/lock handshake bundle for the relock controller.
interface red_pitaya_limit_relock_ctrl_if #(
  parameter int DW = 14,
  parameter int CW = 20,
  parameter int RW = 16
);
  logic                 enable_i;
  logic signed [DW-1:0] lock_min_i;
  logic signed [DW-1:0] lock_max_i;
  logic        [DW-1:0] sweep_step_i;
  logic        [CW-1:0] rail_cycles_i;
  logic        [CW-1:0] settle_cycles_i;
  logic        [1:0]    railed_i;
  logic                 lock_detect_i;
  logic signed [DW-1:0] min_val_o;
  logic signed [DW-1:0] max_val_o;
  logic signed [DW-1:0] offset_o;
  logic                 int_reset_o;
  logic        [1:0]    state_o;
  logic        [RW-1:0] relock_cnt_o;

  // Driver side: supplies configuration and rail/lock flags, observes status.
  modport master (
    output enable_i, lock_min_i, lock_max_i, sweep_step_i, rail_cycles_i,
           settle_cycles_i, railed_i, lock_detect_i,
    input  min_val_o, max_val_o, offset_o, int_reset_o, state_o, relock_cnt_o
  );

  // Controller side.
  modport slave (
    input  enable_i, lock_min_i, lock_max_i, sweep_step_i, rail_cycles_i,
           settle_cycles_i, railed_i, lock_detect_i,
    output min_val_o, max_val_o, offset_o, int_reset_o, state_o, relock_cnt_o
  );
endinterface

// File: rtl/red_pitaya_limit_relock_ctrl.sv
// Relock sequencer for one lockbox channel: detects a railed loop, sweeps a
// triangular offset inside the limit window until lock is detected, then
// waits a settle period before declaring lock. Also owns the limit window.
module red_pitaya_limit_relock_ctrl #(
  parameter int DW = 14,
  parameter int CW = 20,
  parameter int RW = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  red_pitaya_limit_relock_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_SWEEP  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  // Two guard bits: a full-range offset plus a full-range unsigned step
  // must not wrap before it is compared against the window.
  localparam int AW = DW + 2;

  state_t               r_state, w_state_nxt;
  logic signed [DW-1:0] r_offset, w_offset_nxt;
  logic                 r_dir_down, w_dir_down_nxt;
  logic        [CW-1:0] r_rail_cnt, w_rail_cnt_nxt;
  logic        [CW-1:0] r_settle_cnt, w_settle_cnt_nxt;
  logic        [RW-1:0] r_relock_cnt, w_relock_cnt_nxt;
  logic                 r_int_reset, w_int_reset_nxt;
  logic signed [DW-1:0] r_min_val, r_max_val;

  logic signed [AW-1:0] w_off_ext, w_min_ext, w_max_ext, w_step_ext, w_step_sum;
  logic        [CW-1:0] w_rail_limit;
  logic        [CW:0]   w_rail_inc, w_settle_inc;
  logic                 w_rail_done, w_settle_done, w_railed, w_window_empty;
  logic        [RW-1:0] w_relock_inc;

  assign w_off_ext  = {{2{r_offset[DW-1]}}, r_offset};
  assign w_min_ext  = {{2{bus.lock_min_i[DW-1]}}, bus.lock_min_i};
  assign w_max_ext  = {{2{bus.lock_max_i[DW-1]}}, bus.lock_max_i};
  assign w_step_ext = {2'b00, bus.sweep_step_i};
  assign w_step_sum = r_dir_down ? (w_off_ext - w_step_ext) : (w_off_ext + w_step_ext);

  assign w_window_empty = ($signed(bus.lock_min_i) >= $signed(bus.lock_max_i));
  assign w_railed       = (bus.railed_i != 2'b00);

  // A zero rail threshold behaves like one railed cycle.
  assign w_rail_limit  = (bus.rail_cycles_i == {CW{1'b0}}) ? {{(CW-1){1'b0}}, 1'b1} : bus.rail_cycles_i;
  assign w_rail_inc    = {1'b0, r_rail_cnt} + {{CW{1'b0}}, 1'b1};
  assign w_settle_inc  = {1'b0, r_settle_cnt} + {{CW{1'b0}}, 1'b1};
  assign w_rail_done   = (w_rail_inc >= {1'b0, w_rail_limit});
  assign w_settle_done = (w_settle_inc >= {1'b0, bus.settle_cycles_i});
  assign w_relock_inc  = (&r_relock_cnt) ? r_relock_cnt : (r_relock_cnt + {{(RW-1){1'b0}}, 1'b1});

  // Next-state, sweep arithmetic and counter update for the relock sequence.
  always_comb begin
    w_state_nxt      = r_state;
    w_offset_nxt     = r_offset;
    w_dir_down_nxt   = r_dir_down;
    w_rail_cnt_nxt   = r_rail_cnt;
    w_settle_cnt_nxt = r_settle_cnt;
    w_relock_cnt_nxt = r_relock_cnt;
    w_int_reset_nxt  = r_int_reset;

    if (!bus.enable_i) begin
      w_state_nxt      = ST_IDLE;
      w_offset_nxt     = {DW{1'b0}};
      w_dir_down_nxt   = 1'b0;
      w_rail_cnt_nxt   = {CW{1'b0}};
      w_settle_cnt_nxt = {CW{1'b0}};
      w_int_reset_nxt  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt     = ST_SWEEP;
          w_offset_nxt    = bus.lock_min_i;
          w_dir_down_nxt  = 1'b0;
          w_int_reset_nxt = 1'b1;
        end
        ST_LOCKED: begin
          w_int_reset_nxt = 1'b0;
          if (w_railed) begin
            if (w_rail_done) begin
              w_state_nxt      = ST_SWEEP;
              w_relock_cnt_nxt = w_relock_inc;
              w_rail_cnt_nxt   = {CW{1'b0}};
              w_int_reset_nxt  = 1'b1;
            end else begin
              w_rail_cnt_nxt = w_rail_inc[CW-1:0];
            end
          end else begin
            w_rail_cnt_nxt = {CW{1'b0}};
          end
        end
        ST_SWEEP: begin
          w_int_reset_nxt = 1'b1;
          // A railed loop cannot be trusted to be locked, so rails mask detect.
          if (bus.lock_detect_i && !w_railed) begin
            w_state_nxt      = ST_SETTLE;
            w_settle_cnt_nxt = {CW{1'b0}};
            w_int_reset_nxt  = 1'b0;
          end else if (w_window_empty) begin
            w_offset_nxt = bus.lock_min_i;
          end else if (w_step_sum >= w_max_ext) begin
            w_offset_nxt   = bus.lock_max_i;
            w_dir_down_nxt = 1'b1;
          end else if (w_step_sum <= w_min_ext) begin
            w_offset_nxt   = bus.lock_min_i;
            w_dir_down_nxt = 1'b0;
          end else begin
            w_offset_nxt = w_step_sum[DW-1:0];
          end
        end
        ST_SETTLE: begin
          w_int_reset_nxt = 1'b0;
          if (w_railed) begin
            w_state_nxt      = ST_SWEEP;
            w_settle_cnt_nxt = {CW{1'b0}};
            w_int_reset_nxt  = 1'b1;
          end else if (w_settle_done) begin
            w_state_nxt      = ST_LOCKED;
            w_settle_cnt_nxt = {CW{1'b0}};
            w_rail_cnt_nxt   = {CW{1'b0}};
          end else begin
            w_settle_cnt_nxt = w_settle_inc[CW-1:0];
          end
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_offset_nxt    = {DW{1'b0}};
          w_dir_down_nxt  = 1'b0;
          w_int_reset_nxt = 1'b1;
        end
      endcase
    end
  end

  // Sequencer state, offset, direction and counters.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ST_IDLE;
      r_offset     <= {DW{1'b0}};
      r_dir_down   <= 1'b0;
      r_rail_cnt   <= {CW{1'b0}};
      r_settle_cnt <= {CW{1'b0}};
      r_relock_cnt <= {RW{1'b0}};
      r_int_reset  <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_offset     <= w_offset_nxt;
      r_dir_down   <= w_dir_down_nxt;
      r_rail_cnt   <= w_rail_cnt_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_relock_cnt <= w_relock_cnt_nxt;
      r_int_reset  <= w_int_reset_nxt;
    end
  end

  // Limit window forwarded to the limit block, independent of sequencer state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_min_val <= {DW{1'b0}};
      r_max_val <= {DW{1'b0}};
    end else begin
      r_min_val <= bus.lock_min_i;
      r_max_val <= bus.lock_max_i;
    end
  end

  assign bus.min_val_o    = r_min_val;
  assign bus.max_val_o    = r_max_val;
  assign bus.offset_o     = r_offset;
  assign bus.int_reset_o  = r_int_reset;
  assign bus.state_o      = r_state;
  assign bus.relock_cnt_o = r_relock_cnt;

endmodule

// File: tb/tb_red_pitaya_limit_relock_ctrl.sv
// Bench for the relock sequencer: vector table, directed corner sequences and
// a randomized run against a behavioural model of the sequence rules.
module tb_red_pitaya_limit_relock_ctrl;

  localparam int DW = 14;
  localparam int CW = 20;
  localparam int RW = 16;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  red_pitaya_limit_relock_ctrl_if #(.DW(DW), .CW(CW), .RW(RW)) bus ();

  red_pitaya_limit_relock_ctrl #(.DW(DW), .CW(CW), .RW(RW)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: state as small integer (0 idle, 1 locked, 2 sweep, 3 settle).
  int m_state, m_off, m_relocks, m_min, m_max, m_run, m_elapsed;
  bit m_up, m_intr;

  typedef struct {
    bit   en;
    int   lmin;
    int   lmax;
    int   step;
    bit   ld;
    bit [1:0] railed;
    int   exp_state;
    int   exp_off;
    bit   exp_intr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit en, int lmin, int lmax, int step, bit ld, bit [1:0] railed,
                              int es, int eo, bit ei);
    vec_t v;
    v.en = en; v.lmin = lmin; v.lmax = lmax; v.step = step; v.ld = ld; v.railed = railed;
    v.exp_state = es; v.exp_off = eo; v.exp_intr = ei;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_off = 0; m_intr = 1'b1; m_relocks = 0;
    m_min = 0; m_max = 0; m_up = 1'b1; m_run = 0; m_elapsed = 0;
  endtask

  // Applies the behaviour rules to the inputs present at the clock edge.
  task automatic model_step();
    bit en, ld, railed;
    int lmin, lmax, step, rc, sc, t;
    en     = bus.enable_i;
    ld     = bus.lock_detect_i;
    railed = (bus.railed_i != 2'b00);
    lmin   = int'($signed(bus.lock_min_i));
    lmax   = int'($signed(bus.lock_max_i));
    step   = int'(bus.sweep_step_i);
    rc     = int'(bus.rail_cycles_i);
    sc     = int'(bus.settle_cycles_i);
    m_min  = lmin;
    m_max  = lmax;
    if (!en) begin
      m_state = 0; m_off = 0; m_intr = 1'b1; m_run = 0; m_elapsed = 0; m_up = 1'b1;
    end else if (m_state == 0) begin
      m_state = 2; m_off = lmin; m_up = 1'b1; m_intr = 1'b1;
    end else if (m_state == 1) begin
      m_intr = 1'b0;
      if (railed) begin
        m_run++;
        if (m_run >= ((rc < 1) ? 1 : rc)) begin
          m_state = 2; m_run = 0; m_intr = 1'b1;
          if (m_relocks < 65535) m_relocks++;
        end
      end else begin
        m_run = 0;
      end
    end else if (m_state == 2) begin
      m_intr = 1'b1;
      if (ld && !railed) begin
        m_state = 3; m_elapsed = 0; m_intr = 1'b0;
      end else if (lmin >= lmax) begin
        m_off = lmin;
      end else begin
        t = m_up ? (m_off + step) : (m_off - step);
        if (t >= lmax) begin
          m_off = lmax; m_up = 1'b0;
        end else if (t <= lmin) begin
          m_off = lmin; m_up = 1'b1;
        end else begin
          m_off = t;
        end
      end
    end else begin
      m_intr = 1'b0;
      m_elapsed++;
      if (railed) begin
        m_state = 2; m_intr = 1'b1;
      end else if (m_elapsed >= sc) begin
        m_state = 1; m_run = 0;
      end
    end
  endtask

  task automatic compare_model();
    check("state",      int'(bus.state_o),             m_state);
    check("offset",     int'($signed(bus.offset_o)),   m_off);
    check("int_reset",  int'(bus.int_reset_o),         int'(m_intr));
    check("relock_cnt", int'(bus.relock_cnt_o),        m_relocks);
    check("min_val",    int'($signed(bus.min_val_o)),  m_min);
    check("max_val",    int'($signed(bus.max_val_o)),  m_max);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic drive(input bit en, input int lmin, input int lmax, input int step,
                       input bit ld, input bit [1:0] railed);
    bus.enable_i      = en;
    bus.lock_min_i    = DW'(lmin);
    bus.lock_max_i    = DW'(lmax);
    bus.sweep_step_i  = DW'(step);
    bus.lock_detect_i = ld;
    bus.railed_i      = railed;
  endtask

  task automatic expect_out(input string tag, input int st, input int off, input int intr, input int rc);
    check({tag, "_state"},  int'(bus.state_o),           st);
    check({tag, "_offset"}, int'($signed(bus.offset_o)), off);
    check({tag, "_intr"},   int'(bus.int_reset_o),       intr);
    check({tag, "_relock"}, int'(bus.relock_cnt_o),      rc);
  endtask

  initial begin
    int lmin_r, lmax_r;
    checks = 0;
    failures = 0;
    rstn = 1'b0;
    drive(1'b0, -4000, 4000, 1000, 1'b0, 2'b00);
    bus.rail_cycles_i   = CW'(10);
    bus.settle_cycles_i = CW'(5);
    model_reset();

    // Reset state while held in reset.
    #12;
    expect_out("rst", 0, 0, 1, 0);
    check("rst_min", int'($signed(bus.min_val_o)), 0);
    check("rst_max", int'($signed(bus.max_val_o)), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Vector table: idle, then triangle sweeps with step 1000 and step 3000.
    vecs.push_back(mk(1'b0, -4000, 4000, 1000, 1'b0, 2'b00, 0, 0, 1'b1));
    vecs.push_back(mk(1'b1, -4000, 4000, 1000, 1'b0, 2'b00, 2, -4000, 1'b1));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1'b1, -4000, 4000, 1000, 1'b0, 2'b00, 2, -4000 + 1000 * k, 1'b1));
    vecs.push_back(mk(1'b1, -4000, 4000, 1000, 1'b0, 2'b00, 2, 3000, 1'b1));
    vecs.push_back(mk(1'b1, -4000, 4000, 1000, 1'b0, 2'b00, 2, 2000, 1'b1));
    vecs.push_back(mk(1'b0, -4000, 4000, 3000, 1'b0, 2'b00, 0, 0, 1'b1));
    vecs.push_back(mk(1'b1, -4000, 4000, 3000, 1'b0, 2'b00, 2, -4000, 1'b1));
    vecs.push_back(mk(1'b1, -4000, 4000, 3000, 1'b0, 2'b00, 2, -1000, 1'b1));
    vecs.push_back(mk(1'b1, -4000, 4000, 3000, 1'b0, 2'b00, 2, 2000, 1'b1));
    vecs.push_back(mk(1'b1, -4000, 4000, 3000, 1'b0, 2'b00, 2, 4000, 1'b1));
    vecs.push_back(mk(1'b1, -4000, 4000, 3000, 1'b0, 2'b00, 2, 1000, 1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].lmin, vecs[i].lmax, vecs[i].step, vecs[i].ld, vecs[i].railed);
      tick();
      check($sformatf("vec%0d_state", i),  int'(bus.state_o),           vecs[i].exp_state);
      check($sformatf("vec%0d_offset", i), int'($signed(bus.offset_o)), vecs[i].exp_off);
      check($sformatf("vec%0d_intr", i),   int'(bus.int_reset_o),       int'(vecs[i].exp_intr));
      if (i == 0) begin
        check("vec0_min", int'($signed(bus.min_val_o)), -4000);
        check("vec0_max", int'($signed(bus.max_val_o)), 4000);
      end
    end

    // Lock detect freezes the offset; settle of 5 cycles then LOCKED.
    bus.settle_cycles_i = CW'(5);
    bus.lock_detect_i = 1'b1;
    tick();
    expect_out("settle_entry", 3, 1000, 0, 0);
    bus.lock_detect_i = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    expect_out("settle_hold", 3, 1000, 0, 0);
    tick();
    expect_out("locked", 1, 1000, 0, 0);

    // Rail burst of 9 does not unlock; a burst of 10 does.
    bus.rail_cycles_i = CW'(10);
    bus.railed_i = 2'b10;
    for (int k = 0; k < 9; k++) tick();
    expect_out("burst9", 1, 1000, 0, 0);
    bus.railed_i = 2'b00;
    tick();
    bus.railed_i = 2'b10;
    for (int k = 0; k < 9; k++) tick();
    expect_out("burst2_9", 1, 1000, 0, 0);
    tick();
    expect_out("burst2_10", 2, 1000, 1, 1);
    bus.railed_i = 2'b00;

    // Railing on the cycle the settle count completes returns to SWEEP.
    bus.settle_cycles_i = CW'(3);
    bus.lock_detect_i = 1'b1;
    tick();
    expect_out("s5_entry", 3, 1000, 0, 1);
    bus.lock_detect_i = 1'b0;
    tick();
    tick();
    bus.railed_i = 2'b01;
    tick();
    expect_out("s5_rail", 2, 1000, 1, 1);
    bus.railed_i = 2'b00;

    // Disable in SETTLE, then an empty window holds the offset at lock_min.
    bus.lock_detect_i = 1'b1;
    tick();
    check("s6_settle", int'(bus.state_o), 3);
    bus.lock_detect_i = 1'b0;
    bus.enable_i = 1'b0;
    tick();
    expect_out("s6_idle", 0, 0, 1, 1);
    drive(1'b1, 1000, 1000, 3000, 1'b0, 2'b00);
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_out($sformatf("s6_flat%0d", k), 2, 1000, 1, 1);
    end

    // rail_cycles=0 acts as 1; settle_cycles=0 locks on the cycle after entry.
    drive(1'b1, -4000, 4000, 500, 1'b1, 2'b00);
    bus.settle_cycles_i = CW'(0);
    bus.rail_cycles_i   = CW'(0);
    tick();
    check("z_settle", int'(bus.state_o), 3);
    bus.lock_detect_i = 1'b0;
    tick();
    check("z_locked", int'(bus.state_o), 1);
    bus.railed_i = 2'b01;
    tick();
    expect_out("z_unlock", 2, 1000, 1, 2);
    bus.railed_i = 2'b00;
    tick();

    // Asynchronous reset mid-sweep.
    rstn = 1'b0;
    #1;
    expect_out("arst", 0, 0, 1, 0);
    check("arst_min", int'($signed(bus.min_val_o)), 0);
    model_reset();
    #2;
    rstn = 1'b1;

    // Randomized run against the model.
    lmin_r = -3000;
    lmax_r = 3000;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        lmin_r = int'($urandom_range(0, 16383)) - 8192;
        lmax_r = int'($urandom_range(0, 16383)) - 8192;
        if ($urandom_range(0, 3) != 0 && lmin_r > lmax_r) begin
          int tmp;
          tmp = lmin_r; lmin_r = lmax_r; lmax_r = tmp;
        end
      end
      bus.enable_i        = ($urandom_range(0, 99) != 0);
      bus.lock_min_i      = DW'(lmin_r);
      bus.lock_max_i      = DW'(lmax_r);
      bus.sweep_step_i    = ($urandom_range(0, 9) == 0) ? DW'(0) :
                            ($urandom_range(0, 19) == 0) ? DW'($urandom_range(0, 16383)) :
                            DW'($urandom_range(1, 2500));
      bus.rail_cycles_i   = CW'($urandom_range(0, 6));
      bus.settle_cycles_i = CW'($urandom_range(0, 6));
      bus.lock_detect_i   = ($urandom_range(0, 24) == 0);
      bus.railed_i        = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
